clk_div_sched: RTL

CLK_DIV_SCHED -- requirements
Module: clk_div_sched

---
 rtl/clk_div_pkg.sv | 34 +++
 rtl/clk_div_sched_if.sv | 31 +++
 rtl/clk_div_core.sv | 51 +++++
 rtl/clk_div_sched.sv | 105 ++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock-divider scheduler: ratio selects,
// half-period reload table and FSM state encodings.
package clk_div_pkg;

   localparam int CNT_W = 5;

   // Divide-ratio select as carried on i_sel / o_cur_sel.
   typedef enum logic [1:0] {
      SEL_DIV2  = 2'd0,
      SEL_DIV4  = 2'd1,
      SEL_DIV16 = 2'd2,
      SEL_DIV64 = 2'd3
   } sel_t;

   // Ratio-change handshake states.
   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_PEND = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   // Half-period reload: a phase lasts reload+1 cycles.
   function automatic logic [CNT_W-1:0] reload_of(input logic [1:0] sel);
      logic [CNT_W-1:0] r;
      case (sel)
         SEL_DIV2:  r = 5'd0;
         SEL_DIV4:  r = 5'd1;
         SEL_DIV16: r = 5'd7;
         default:   r = 5'd31;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/clk_div_sched_if.sv
// Control/status bundle of the clock-divider scheduler.
//
// Handshake: i_req is a one-cycle request carrying i_sel; it is accepted on
// any rising edge where o_busy is low (RUN or ACK state). o_busy stays high
// from the cycle after acceptance until the new ratio takes effect, which is
// marked by a single-cycle o_ack with o_cur_sel already updated. Requests
// presented while o_busy is high are dropped.
interface clk_div_sched_if;
   import clk_div_pkg::*;

   logic       i_en;
   logic       i_req;
   logic [1:0] i_sel;
   logic       o_busy;
   logic       o_ack;
   logic [1:0] o_cur_sel;
   logic       o_gen_clk;
   logic       o_tick;
   state_t     o_dbg_state;

   modport slave (
      input  i_en, i_req, i_sel,
      output o_busy, o_ack, o_cur_sel, o_gen_clk, o_tick, o_dbg_state
   );

   modport master (
      output i_en, i_req, i_sel,
      input  o_busy, o_ack, o_cur_sel, o_gen_clk, o_tick, o_dbg_state
   );

endinterface

// File: rtl/clk_div_core.sv
// Half-period down-counter and registered toggle producing the divided clock.
// A load forces the output low and restarts the count from i_reload; it is
// used both for clean ratio switches and for holding the clock while stopped.
module clk_div_core
   import clk_div_pkg::*;
#(
   parameter logic [CNT_W-1:0] RST_RELOAD = 5'd1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_reload,
   output logic [CNT_W-1:0] o_count,
   output logic             o_gen_clk,
   output logic             o_tick
);

   logic [CNT_W-1:0] count_q;
   logic             gen_q;
   logic             tick_q;

   // Count down, toggle and reload at zero; tick marks the first high cycle.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         count_q <= RST_RELOAD;
         gen_q   <= 1'b0;
         tick_q  <= 1'b0;
      end else if (i_load) begin
         count_q <= i_reload;
         gen_q   <= 1'b0;
         tick_q  <= 1'b0;
      end else if (i_en) begin
         if (count_q == '0) begin
            count_q <= i_reload;
            gen_q   <= ~gen_q;
            tick_q  <= ~gen_q;
         end else begin
            count_q <= count_q - CNT_W'(1);
            tick_q  <= 1'b0;
         end
      end else begin
         tick_q <= 1'b0;
      end
   end

   assign o_count   = count_q;
   assign o_gen_clk = gen_q;
   assign o_tick    = tick_q;

endmodule

// File: rtl/clk_div_sched.sv
// Clock divider with glitch-free ratio switching. A requested ratio is held
// pending until the end of a high phase (or immediately when the clock is
// parked low), so no generated phase is ever shortened.
module clk_div_sched
   import clk_div_pkg::*;
#(
   parameter logic [1:0] RST_SEL = 2'd1
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   clk_div_sched_if.slave  bus
);

   state_t           state_q, state_d;
   logic [1:0]       cur_q, cur_d;
   logic [1:0]       pend_q, pend_d;
   logic             busy_q, ack_q;

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] reload;
   logic             gen_clk;
   logic             tick;
   logic             stopped;
   logic             boundary;
   logic             load_new;
   logic             core_load;
   logic             core_en;

   // Parked: disabled and already low, so the output can be held there.
   assign stopped   = ~bus.i_en & ~gen_clk;
   // Period boundary: last cycle of a high phase, or parked low.
   assign boundary  = ((count == '0) & gen_clk) | stopped;
   assign load_new  = (state_q == ST_PEND) & boundary;
   assign core_load = load_new | stopped;
   assign core_en   = ~stopped;
   assign reload    = load_new ? reload_of(pend_q) : reload_of(cur_q);

   clk_div_core #(
      .RST_RELOAD (reload_of(RST_SEL))
   ) u_core (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_en      (core_en),
      .i_load    (core_load),
      .i_reload  (reload),
      .o_count   (count),
      .o_gen_clk (gen_clk),
      .o_tick    (tick)
   );

   // Next-state: accept requests in RUN/ACK, switch ratio at the boundary.
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      pend_d  = pend_q;
      case (state_q)
         ST_RUN: begin
            if (bus.i_req) begin
               pend_d  = bus.i_sel;
               state_d = ST_PEND;
            end
         end
         ST_PEND: begin
            if (boundary) begin
               cur_d   = pend_q;
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            if (bus.i_req) begin
               pend_d  = bus.i_sel;
               state_d = ST_PEND;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // State and registered handshake outputs.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= ST_RUN;
         cur_q   <= RST_SEL;
         pend_q  <= RST_SEL;
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         pend_q  <= pend_d;
         busy_q  <= (state_d == ST_PEND);
         ack_q   <= (state_d == ST_ACK);
      end
   end

   assign bus.o_busy      = busy_q;
   assign bus.o_ack       = ack_q;
   assign bus.o_cur_sel   = cur_q;
   assign bus.o_gen_clk   = gen_clk;
   assign bus.o_tick      = tick;
   assign bus.o_dbg_state = state_q;

endmodule
